// File: rtl/pwm_gen_multi_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator and the
// control FSM that feeds it duty values.
package pwm_pkg;

  localparam int PERIOD_DFLT = 100;

  localparam int DUTY_OFF  = 0;
  localparam int DUTY_LOW  = 40;
  localparam int DUTY_MID  = 70;
  localparam int DUTY_HIGH = 95;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MID  = 2'd2,
    LVL_HIGH = 2'd3
  } motor_lvl_e;

  // Bits needed to hold values 0..value-1; callers pass PERIOD+1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int level_duty(input motor_lvl_e lvl);
    int d;
    d = DUTY_OFF;
    case (lvl)
      LVL_LOW:  d = DUTY_LOW;
      LVL_MID:  d = DUTY_MID;
      LVL_HIGH: d = DUTY_HIGH;
      default:  d = DUTY_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_gen_multi_if.sv
// Control/observation bundle between the control FSM (master) and the PWM block
// (slave); duty is packed per channel, channel k at [k*CNT_W +: CNT_W].
interface pwm_gen_multi_if
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = clog2(PERIOD_DFLT + 1)
);
  logic                      i_en;
  logic                      i_load;
  logic [NUM_CH*CNT_W-1:0]   i_duty;
  logic [NUM_CH-1:0]         o_pwm;
  logic                      o_period_end;
  logic [NUM_CH-1:0]         o_settled;

  modport master (
    output i_en, i_load, i_duty,
    input  o_pwm, o_period_end, o_settled
  );

  modport slave (
    input  i_en, i_load, i_duty,
    output o_pwm, o_period_end, o_settled
  );
endinterface

// File: rtl/pwm_gen_multi_channel.sv
// One PWM channel: clamped target, boundary-applied (optionally ramped) active
// compare, registered output one cycle after the counter value.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W     = 7,
  parameter int PERIOD    = PERIOD_DFLT,
  parameter int RAMP_STEP = 0,
  parameter bit INVERT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary,
  output logic             pwm,
  output logic             settled
);

  localparam int STEP_C = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;
  localparam logic [CNT_W:0] PERIOD_W = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0] STEP_W   = (CNT_W + 1)'(STEP_C);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] duty_clamped;
  logic [CNT_W-1:0] active_nxt;
  logic [CNT_W:0]   gap;
  logic [CNT_W:0]   stp;
  logic [CNT_W:0]   sum;

  assign duty_clamped = ({1'b0, duty} > PERIOD_W) ? PERIOD_W[CNT_W-1:0] : duty;

  // The step is limited to the remaining gap, so the ramp never overshoots.
  always_comb begin
    gap        = '0;
    stp        = '0;
    sum        = '0;
    active_nxt = active;
    if (RAMP_STEP == 0) begin
      active_nxt = target;
    end else if (target > active) begin
      gap        = {1'b0, target} - {1'b0, active};
      stp        = (gap < STEP_W) ? gap : STEP_W;
      sum        = {1'b0, active} + stp;
      active_nxt = (sum > PERIOD_W) ? PERIOD_W[CNT_W-1:0] : sum[CNT_W-1:0];
    end else begin
      gap        = {1'b0, active} - {1'b0, target};
      stp        = (gap < STEP_W) ? gap : STEP_W;
      sum        = {1'b0, active} - stp;
      active_nxt = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      active <= '0;
      pwm    <= INVERT;
    end else begin
      if (load) target <= duty_clamped;
      // Disable drops the compare to 0 so a re-enable ramps up from scratch.
      if (!en) begin
        active <= '0;
      end else if (boundary) begin
        active <= active_nxt;
      end
      pwm <= ((cnt < active) && en) ^ INVERT;
    end
  end

  assign settled = (active == target);

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM: shared 0..PERIOD-1 counter, period-end pulse one cycle after
// the wrap edge, and NUM_CH compare channels with outputs one cycle behind cnt.
module pwm_gen_multi
  import pwm_pkg::*;
#(
  parameter int                NUM_CH    = 2,
  parameter int                PERIOD    = PERIOD_DFLT,
  parameter int                RAMP_STEP = 0,
  parameter logic [NUM_CH-1:0] INVERT    = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  pwm_gen_multi_if.slave  bus
);

  localparam int CNT_W = clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  cnt;
  logic              boundary;
  logic              period_end;
  logic [NUM_CH-1:0] pwm_vec;
  logic [NUM_CH-1:0] settled_vec;

  assign boundary = bus.i_en && (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      period_end <= boundary;
      if (!bus.i_en || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_channel #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .RAMP_STEP (RAMP_STEP),
      .INVERT    (INVERT[k])
    ) u_ch (
      .clk      (i_clk),
      .rst      (i_rst),
      .en       (bus.i_en),
      .load     (bus.i_load),
      .duty     (bus.i_duty[k*CNT_W +: CNT_W]),
      .cnt      (cnt),
      .boundary (boundary),
      .pwm      (pwm_vec[k]),
      .settled  (settled_vec[k])
    );
  end

  assign bus.o_pwm        = pwm_vec;
  assign bus.o_settled    = settled_vec;
  assign bus.o_period_end = period_end;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Directed bench: dut_a has no ramp and plain polarity, dut_b ramps by 10 with
// channel 1 inverted; outputs sampled on the falling edge.
module tb_pwm_gen_multi;
  import pwm_pkg::*;

  localparam int PER = 100;
  localparam int CW  = clog2(PER + 1);

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pwm_gen_multi_if #(.NUM_CH(2), .CNT_W(CW)) bus_a ();
  pwm_gen_multi_if #(.NUM_CH(2), .CNT_W(CW)) bus_b ();

  pwm_gen_multi #(.NUM_CH(2), .PERIOD(PER), .RAMP_STEP(0), .INVERT(2'b00)) dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  pwm_gen_multi #(.NUM_CH(2), .PERIOD(PER), .RAMP_STEP(10), .INVERT(2'b10)) dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Polarity-normalised output: 1 means the channel is asserted.
  function automatic logic [1:0] pwm_n(input bit sel);
    return sel ? (bus_b.o_pwm ^ 2'b10) : bus_a.o_pwm;
  endfunction

  function automatic logic pe(input bit sel);
    return sel ? bus_b.o_period_end : bus_a.o_period_end;
  endfunction

  function automatic logic [1:0] stl(input bit sel);
    return sel ? bus_b.o_settled : bus_a.o_settled;
  endfunction

  task automatic set_load(input bit sel, input logic v, input logic [2*CW-1:0] d);
    if (sel) begin
      bus_b.i_load = v;
      if (v) bus_b.i_duty = d;
    end else begin
      bus_a.i_load = v;
      if (v) bus_a.i_duty = d;
    end
  endtask

  task automatic wait_pe(input bit sel, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2*PER && !found; i++) begin
      @(negedge clk);
      if (pe(sel)) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Called in a period_end cycle; samples one full 100-cycle window and ends
  // in the next period_end cycle. Optionally strobes a load when cnt==load_at.
  task automatic measure(input bit sel, input string tag, input int exp0, input int exp1,
                         input logic [1:0] exp_set, input int load_at,
                         input logic [2*CW-1:0] load_dat);
    int hi0, hi1, pe_early;
    logic cont0, cont1, pe_last;
    logic [1:0] p;
    hi0 = 0; hi1 = 0; pe_early = 0;
    cont0 = 1'b1; cont1 = 1'b1; pe_last = 1'b0;
    chk({tag, ".settled"}, 32'(stl(sel)), 32'(exp_set));
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      set_load(sel, 1'b0, '0);
      p = pwm_n(sel);
      if (p[0]) begin
        if (hi0 != i - 1) cont0 = 1'b0;
        hi0++;
      end
      if (p[1]) begin
        if (hi1 != i - 1) cont1 = 1'b0;
        hi1++;
      end
      if (i < PER && pe(sel)) pe_early++;
      if (i == PER) pe_last = pe(sel);
      if (i == load_at) set_load(sel, 1'b1, load_dat);
    end
    chk({tag, ".high0"}, 32'(hi0), 32'(exp0));
    chk({tag, ".high1"}, 32'(hi1), 32'(exp1));
    chk({tag, ".contig"}, 32'({cont1, cont0}), 32'd3);
    chk({tag, ".pe_mid"}, 32'(pe_early), 32'd0);
    chk({tag, ".pe_end"}, 32'(pe_last), 32'd1);
  endtask

  // Counter is expected to sit at 0 with active=0: no pulse for 99 cycles,
  // pulse on the 100th, outputs idle throughout.
  task automatic idle_to_pe(input bit sel, input string tag);
    int pe_early, busy;
    logic pe_last;
    pe_early = 0; busy = 0; pe_last = 1'b0;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      if (pwm_n(sel) != 2'b00) busy++;
      if (i < PER && pe(sel)) pe_early++;
      if (i == PER) pe_last = pe(sel);
    end
    chk({tag, ".pe_mid"}, 32'(pe_early), 32'd0);
    chk({tag, ".pe_end"}, 32'(pe_last), 32'd1);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_en = 1'b0; bus_a.i_load = 1'b0; bus_a.i_duty = '0;
    bus_b.i_en = 1'b0; bus_b.i_load = 1'b0; bus_b.i_duty = '0;
    repeat (2) @(negedge clk);

    chk("rst.a_pwm", 32'(bus_a.o_pwm), 32'd0);
    chk("rst.a_pe", 32'(bus_a.o_period_end), 32'd0);
    chk("rst.a_settled", 32'(bus_a.o_settled), 32'd3);
    chk("rst.b_pwm", 32'(bus_b.o_pwm), 32'd2);
    chk("rst.b_settled", 32'(bus_b.o_settled), 32'd3);

    // Basic duty 40/70 from the first boundary
    rst_a = 1'b0; bus_a.i_en = 1'b1;
    bus_a.i_load = 1'b1; bus_a.i_duty = {7'd70, 7'd40};
    @(negedge clk);
    bus_a.i_load = 1'b0;
    chk("t1.settled_pre", 32'(bus_a.o_settled), 32'd0);
    wait_pe(0, "t1.first_pe");
    measure(0, "t1.p1", 40, 70, 2'b11, 0, '0);
    measure(0, "t1.p2", 40, 70, 2'b11, 20, {7'd120, 7'd0});

    // 0 and clamped 120 -> constant levels across wraps
    measure(0, "t2.w1", 0, 100, 2'b11, 0, '0);
    measure(0, "t2.w2", 0, 100, 2'b11, 0, '0);
    measure(0, "t2.w3", 0, 100, 2'b11, 50, {7'd70, 7'd40});

    // Mid-period load, then load in the boundary cycle
    measure(0, "t4.pre", 40, 70, 2'b11, 20, {7'd70, 7'd70});
    measure(0, "t4.new", 70, 70, 2'b11, 99, {7'd70, 7'd40});
    measure(0, "t4.coll", 70, 70, 2'b10, 0, '0);
    measure(0, "t4.late", 40, 70, 2'b11, 0, '0);

    // Disable at cnt=30, re-enable with no ramp
    repeat (30) @(negedge clk);
    bus_a.i_en = 1'b0;
    @(negedge clk);
    chk("t5.a_idle", 32'(bus_a.o_pwm), 32'd0);
    chk("t5.a_settled", 32'(bus_a.o_settled), 32'd0);
    chk("t5.a_pe", 32'(bus_a.o_period_end), 32'd0);
    bus_a.i_en = 1'b1;
    idle_to_pe(0, "t5.a_restart");
    measure(0, "t5.a_after", 40, 70, 2'b11, 0, '0);
    bus_a.i_en = 1'b0;

    // Ramp 0 -> 95 in steps of 10 on dut_b
    rst_b = 1'b0; bus_b.i_en = 1'b1;
    bus_b.i_load = 1'b1; bus_b.i_duty = {7'd0, 7'd95};
    @(negedge clk);
    bus_b.i_load = 1'b0;
    wait_pe(1, "t3.first_pe");
    for (int k = 1; k <= 10; k++) begin
      measure(1, $sformatf("t3.ramp%0d", k), (k < 10) ? 10*k : 95, 0,
              (k < 10) ? 2'b10 : 2'b11, 0, '0);
    end

    // Disable with ramp: restart from 10
    repeat (30) @(negedge clk);
    bus_b.i_en = 1'b0;
    @(negedge clk);
    chk("t5.b_idle", 32'(bus_b.o_pwm), 32'd2);
    chk("t5.b_settled", 32'(bus_b.o_settled), 32'd2);
    bus_b.i_en = 1'b1;
    idle_to_pe(1, "t5.b_restart");
    measure(1, "t5.b_ramp", 10, 0, 2'b10, 0, '0);

    // Reset mid-period at cnt=50
    repeat (50) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("t6.pwm", 32'(bus_b.o_pwm), 32'd2);
    chk("t6.pe", 32'(bus_b.o_period_end), 32'd0);
    chk("t6.settled", 32'(bus_b.o_settled), 32'd3);
    rst_b = 1'b0;
    idle_to_pe(1, "t6.restart");
    measure(1, "t6.after", 0, 0, 2'b11, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_gen_multi.md
Name: pwm_gen_multi

Overview:
Multi-channel PWM generator for the washer motor and auxiliary drives: one shared period counter and NUM_CH independent compare channels. Each channel has a shadow duty register that is applied only at the period boundary, plus an optional soft-start ramp. Duty inputs are direct compare values from the control FSM rather than fixed level indices. The block sits between the control FSM and the motor driver and pump outputs.

Parameters:
NUM_CH, 2, number of PWM channels
PERIOD, 100, counter period in i_clk cycles; must be ≥ 2
RAMP_STEP, 0, maximum change of a channel's active compare per period; 0 = apply the target immediately
INVERT, {NUM_CH{1'b0}}, per-channel output polarity mask; 1 = active-low output
CNT_W, clog2(PERIOD+1), localparam; width of the counter and of each duty field

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_en  in  1  global enable; low = counter held, outputs idle
i_load  in  1  one-cycle strobe; captures i_duty into the channel target registers
i_duty  in  NUM_CH*CNT_W  packed per-channel duty; channel k occupies bits [k*CNT_W +: CNT_W]
o_pwm  out  NUM_CH  registered PWM outputs
o_period_end  out  1  one-cycle pulse in the cycle after the counter reaches PERIOD-1
o_settled  out  NUM_CH  1 when a channel's active compare equals its target

Behaviour:
- Reset (i_rst=1 at a clock edge): cnt=0, target[k]=0, active[k]=0, o_pwm=INVERT, o_period_end=0, o_settled=all 1. Reset overrides every other input and takes effect mid-period with no completion of the current period.
- Counter: when i_en=1, cnt counts 0..PERIOD-1 and wraps to 0. When i_en=0, cnt is forced to 0.
- Boundary cycle: the cycle in which cnt==PERIOD-1 and i_en=1. At that edge:
  - cnt wraps to 0;
  - o_period_end is 1 for the following cycle only;
  - each active[k] updates.
- Target load: on i_load=1, target[k] <= min(i_duty field k, PERIOD). Values above PERIOD clamp to PERIOD.
- Active update at the boundary edge uses the pre-edge target value:
  - if RAMP_STEP==0: active <= target;
  - otherwise active moves toward target by min(RAMP_STEP, |target-active|), never overshooting.
- Load/boundary collision: a load in the same cycle as the boundary is not seen by that boundary update. It takes effect at the next boundary, one full period later.
- Output: o_pwm[k] <= ((cnt < active[k]) && i_en) ^ INVERT[k]. This gives one cycle of latency from the counter value.
  - The high time is exactly active[k] cycles per PERIOD-cycle window.
  - active=0 gives a constant idle level.
  - active=PERIOD gives a constant asserted level with no glitch at the wrap.
  - The compare is evaluated on every count value including PERIOD-1; no count value is skipped.
- Disable: when i_en=0, active[k] is forced to 0 at the next edge and targets are retained. On re-enable, the ramp restarts from 0 (soft restart of the motor). o_pwm goes to idle in the cycle after i_en falls.
- o_settled[k] = (active[k]==target[k]), registered combinationally from the state registers (no extra latency).
- Arithmetic: all comparisons are unsigned CNT_W-bit. Ramp add/subtract is computed at CNT_W+1 bits and clamped into [0, PERIOD].

Decomposition:
- Package pwm_pkg:
  - clog2 function;
  - default PERIOD constant (100);
  - motor level constants DUTY_OFF=0, DUTY_LOW=40, DUTY_MID=70, DUTY_HIGH=95, used by the control FSM to drive i_duty.
- Sub-module pwm_channel: holds the target/active registers, ramp logic, compare and polarity for one channel. It takes cnt, the boundary flag, i_en, i_load and its duty field. The top module holds the shared counter and o_period_end and instantiates NUM_CH channels with a generate loop.

Test Plan:
1. PERIOD=100, RAMP_STEP=0; after reset, load ch0=40, ch1=70 → from the first boundary on, o_pwm[0] is high for 40 and o_pwm[1] for 70 consecutive cycles per 100; o_period_end pulses every 100 cycles.
2. Load ch0=0, ch1=120 → o_pwm[0] stays 0 and o_pwm[1] stays 1 (clamped to 100) continuously across 3 wraps; o_settled=2'b11.
3. RAMP_STEP=10, load ch0=95 from 0 → active takes 10,20,…,90,95 on successive boundaries; o_settled[0] rises after the 10th boundary.
4. Load ch0 40→70 at cnt=20 → the current period keeps 40 high cycles and the next period has 70. Repeat with i_load in the boundary cycle → the change appears one period later.
5. Drop i_en at cnt=30 with active=40 → o_pwm idle in the next cycle and cnt=0. Re-enable with RAMP_STEP=10 → the ramp restarts at 10.
6. INVERT=2'b10, assert i_rst at cnt=50 → in the next cycle o_pwm=2'b10, cnt=0, targets=0; no pulse on o_period_end.
